// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues in-order reads with a running PC, tags
// each outstanding read with its PC, and buffers returned words with their PC
// in a circular instruction queue. A redirect flushes the queue and turns all
// in-flight responses into discards.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h1ECEB000,
  parameter int          IQ_DEPTH        = 8,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                imem_addr,
  output logic [3:0]                 imem_rmask,
  output logic [3:0]                 imem_wmask,
  output logic [31:0]                imem_wdata,
  input  logic [31:0]                imem_rdata,
  input  logic                       imem_resp,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       iq_valid,
  output logic [31:0]                iq_instr,
  output logic [31:0]                iq_pc,
  input  logic                       iq_ready,
  output logic [$clog2(IQ_DEPTH):0]  iq_count,
  output logic                       fetch_err
);

  localparam int IW = $clog2(IQ_DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   pc_q, pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] disc_q, disc_d;
  logic [TW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [IW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [31:0] tag_mem [MAX_OUTSTANDING];
  logic [31:0] iq_pc_mem [IQ_DEPTH];
  logic [31:0] iq_ins_mem [IQ_DEPTH];

  logic issue, resp_ok, push, pop;

  // Low address bits of a redirect target are forced to zero.
  logic unused_rpc_lsb;
  assign unused_rpc_lsb = ^redirect_pc[1:0];

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  // Issue reserves a queue slot per in-flight read so a push never overflows.
  assign issue   = rst && !redirect_valid
                && (32'(outst_q) < 32'(MAX_OUTSTANDING))
                && ((32'(count_q) + 32'(outst_q)) < 32'(IQ_DEPTH));
  assign resp_ok = imem_resp && (outst_q != '0);
  assign push    = resp_ok && !redirect_valid && (disc_q == '0);
  assign pop     = iq_valid && iq_ready && !redirect_valid;

  assign imem_addr  = pc_q;
  assign imem_rmask = issue ? 4'hF : 4'h0;
  assign imem_wmask = 4'h0;
  assign imem_wdata = 32'h0;
  assign iq_valid   = (count_q != '0);
  assign iq_instr   = iq_ins_mem[head_q];
  assign iq_pc      = iq_pc_mem[head_q];
  assign iq_count   = count_q;
  assign fetch_err  = err_q;

  // Next-state for PC, in-flight bookkeeping, queue pointers and error flag.
  always_comb begin
    pc_d     = pc_q;
    outst_d  = outst_q;
    disc_d   = disc_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    err_d    = err_q;

    if (redirect_valid)  pc_d = {redirect_pc[31:2], 2'b00};
    else if (issue)      pc_d = pc_q + 32'd4;

    case ({issue, resp_ok})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    if (issue)   tag_wr_d = tag_next(tag_wr_q);
    if (resp_ok) tag_rd_d = tag_next(tag_rd_q);

    // Everything still in flight after a redirect belongs to the old stream.
    if (redirect_valid)
      disc_d = outst_q - OW'(resp_ok);
    else if (resp_ok && (disc_q != '0))
      disc_d = disc_q - OW'(1);

    if (redirect_valid) begin
      count_d = '0;
      tail_d  = head_q;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) tail_d = tail_q + IW'(1);
      if (pop)  head_d = head_q + IW'(1);
    end

    if (imem_resp && (outst_q == '0) && !issue) err_d = 1'b1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      outst_q  <= '0;
      disc_q   <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      disc_q   <= disc_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage arrays: PC tags of in-flight reads and queued {pc, instr} entries.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wr_q] <= pc_q;
    if (push) begin
      iq_pc_mem[tail_q]  <= tag_mem[tag_rd_q];
      iq_ins_mem[tail_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a 1-cycle in-order memory model feeds
// responses, a scoreboard holds the expected queue contents in issue order.
module tb_inst_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h1ECEB000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask, imem_wmask;
  logic [31:0] imem_wdata, imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        iq_valid;
  logic [31:0] iq_instr, iq_pc;
  logic        iq_ready;
  logic [3:0]  iq_count;
  logic        fetch_err;

  always #5 clk = ~clk;

  inst_fetch_queue dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_wmask(imem_wmask),
    .imem_wdata(imem_wdata), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .iq_valid(iq_valid), .iq_instr(iq_instr), .iq_pc(iq_pc),
    .iq_ready(iq_ready), .iq_count(iq_count), .fetch_err(fetch_err)
  );

  typedef struct packed { logic [31:0] addr; logic keep; } pend_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;

  pend_t       pend[$];
  ent_t        expq[$];
  logic [31:0] issued_log[$];
  logic [31:0] next_pc;
  bit          exp_err;
  int          n_chk = 0, n_fail = 0;
  int          issues = 0, pops = 0, pops0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0BADF00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One reset clock; state checks apply once a reset edge has already passed.
  task automatic rst_cycle(input bit chk_state);
    rst = 1'b0; imem_resp = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; iq_ready = 1'b0;
    @(negedge clk);
    chk("rst_rmask", 32'(imem_rmask), 32'h0);
    if (chk_state) begin
      chk("rst_iq_valid", 32'(iq_valid), 32'h0);
      chk("rst_iq_count", 32'(iq_count), 32'h0);
      chk("rst_fetch_err", 32'(fetch_err), 32'h0);
    end
    @(posedge clk); #1;
    pend.delete(); expq.delete();
    exp_err = 1'b0; next_pc = RST_PC;
  endtask

  // One functional clock: drive inputs, sample mid-cycle, update the model.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy,
                       input bit mem_en, input bit spurious);
    pend_t e;
    ent_t  x;
    bit    rsp;
    rst = 1'b1; redirect_valid = redir; redirect_pc = rpc; iq_ready = rdy;
    rsp = 1'b0; e = '0; imem_resp = 1'b0; imem_rdata = '0;
    if (spurious) begin
      imem_resp = 1'b1; imem_rdata = 32'hDEAD0000;
    end else if (mem_en && pend.size() > 0) begin
      e = pend.pop_front(); rsp = 1'b1;
      imem_resp = 1'b1; imem_rdata = mdata(e.addr);
    end
    @(negedge clk);
    chk("iq_count", 32'(iq_count), 32'(expq.size()));
    chk("iq_valid", 32'(iq_valid), 32'(expq.size() != 0));
    chk("fetch_err", 32'(fetch_err), 32'(exp_err));
    if (iq_valid && rdy && !redir && expq.size() > 0) begin
      x = expq.pop_front();
      chk("iq_pc", iq_pc, x.pc);
      chk("iq_instr", iq_instr, x.ins);
      pops++;
    end
    if (redir) chk("rmask_on_redirect", 32'(imem_rmask), 32'h0);
    if (imem_rmask == 4'hF) begin
      chk("imem_addr", imem_addr, next_pc);
      next_pc = next_pc + 32'd4;
      pend.push_back('{imem_addr, 1'b1});
      issued_log.push_back(imem_addr);
      issues++;
    end else begin
      chk("rmask_idle", 32'(imem_rmask), 32'h0);
    end
    if (rsp && e.keep && !redir) expq.push_back('{e.addr, mdata(e.addr)});
    if (redir) begin
      expq.delete();
      foreach (pend[i]) pend[i].keep = 1'b0;
      next_pc = {rpc[31:2], 2'b00};
    end
    if (spurious) exp_err = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; imem_resp = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; iq_ready = 1'b0;
    exp_err = 1'b0; next_pc = RST_PC;
    @(posedge clk); #1;
    rst_cycle(1'b0);
    rst_cycle(1'b1);
    chk("wmask", 32'(imem_wmask), 32'h0);
    chk("wdata", imem_wdata, 32'h0);

    // Stream from reset, then measure steady-state throughput.
    issues = 0;
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("first_issue_cnt", 32'(issues), 32'd1);
    chk("first_issue_addr", issued_log[0], RST_PC);
    repeat (11) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    pops0 = pops;
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("throughput", 32'(pops - pops0), 32'd6);

    // Backpressure: queue fills to exactly IQ_DEPTH reads.
    cycle(1'b1, 32'h1ECEB200, 1'b0, 1'b1, 1'b0);
    issues = 0;
    repeat (14) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("bp_issues", 32'(issues), 32'd8);
    chk("bp_count", 32'(iq_count), 32'd8);
    issues = 0;
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("bp_one_more", 32'(issues), 32'd1);

    // Redirect with two reads in flight.
    repeat (3) cycle(1'b1, 32'h1ECEB300, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("inflight_2", 32'(pend.size()), 32'd2);
    cycle(1'b1, 32'h1ECEB103, 1'b1, 1'b0, 1'b0);
    issued_log.delete();
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("drop_count", 32'(iq_count), 32'h0);
    chk("redir_addr", (issued_log.size() > 0) ? issued_log[0] : 32'hFFFFFFFF, 32'h1ECEB100);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("redir_first_pc", iq_pc, 32'h1ECEB100);

    // Redirect coincident with a response and a pop.
    repeat (4) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("coinc_inflight", 32'(pend.size()), 32'd2);
    chk("coinc_nonempty", 32'(iq_valid), 32'd1);
    cycle(1'b1, 32'h1ECEB400, 1'b1, 1'b1, 1'b0);
    chk("coinc_flush", 32'(iq_count), 32'h0);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("coinc_dropped", 32'(iq_count), 32'h0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("coinc_count", 32'(iq_count), 32'd1);
    chk("coinc_pc", iq_pc, 32'h1ECEB400);

    // PC wrap-around.
    cycle(1'b1, 32'hFFFFFFF8, 1'b1, 1'b1, 1'b0);
    issued_log.delete();
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("wrap_n", 32'(issued_log.size() >= 4), 32'd1);
    if (issued_log.size() >= 4) begin
      chk("wrap0", issued_log[0], 32'hFFFFFFF8);
      chk("wrap1", issued_log[1], 32'hFFFFFFFC);
      chk("wrap2", issued_log[2], 32'h00000000);
      chk("wrap3", issued_log[3], 32'h00000004);
    end

    // Unexpected response sets a sticky error.
    repeat (3) cycle(1'b1, 32'h1ECEB500, 1'b1, 1'b1, 1'b0);
    chk("err_idle", 32'(pend.size()), 32'h0);
    cycle(1'b1, 32'h1ECEB500, 1'b1, 1'b1, 1'b1);
    chk("err_set", 32'(fetch_err), 32'd1);
    repeat (5) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("err_sticky", 32'(fetch_err), 32'd1);

    // Reset mid-stream with two in flight.
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("rst_inflight", 32'(pend.size()), 32'd2);
    rst_cycle(1'b0);
    issued_log.delete();
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("rst_restart", (issued_log.size() > 0) ? issued_log[0] : 32'hFFFFFFFF, RST_PC);
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("rst_err_clear", 32'(fetch_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Front-end fetch stage for the Tomasulo RV32I core. It drives the instruction port of the memory interface with a running PC and supports multiple in-order outstanding reads. Returned words are buffered with their PC in an instruction queue that the decode/dispatch stage drains. A redirect from branch/jump resolution restarts fetch and squashes all in-flight and buffered instructions.

Parameters:
RESET_PC, 32'h1ECEB000, PC loaded on reset (word aligned)
IQ_DEPTH, 8, instruction queue entries (power of 2, >=2)
MAX_OUTSTANDING, 2, maximum issued-but-unanswered reads (1..4)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-low reset (0 = reset, sampled on posedge clk)
imem_addr  out  32  read address (= fetch PC register)
imem_rmask  out  4  4'hF when issuing this cycle, else 4'h0
imem_wmask  out  4  constant 4'h0
imem_wdata  out  32  constant 32'h0
imem_rdata  in  32  read data, valid when imem_resp=1
imem_resp  in  1  one response per issued read, in order, >=1 cycle after issue
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  32  new fetch PC; bits [1:0] ignored, forced 2'b00
iq_valid  out  1  queue non-empty
iq_instr  out  32  head instruction word
iq_pc  out  32  head instruction PC
iq_ready  in  1  consumer pops head when iq_valid & iq_ready
iq_count  out  $clog2(IQ_DEPTH)+1  current queue occupancy
fetch_err  out  1  sticky protocol error flag

Behaviour:
- Reset (rst=0 at posedge): pc<=RESET_PC; queue, tag FIFO, outstanding, discard counters <=0; fetch_err<=0. During reset and the following cycle's combinational outputs: imem_rmask=0, iq_valid=0, iq_count=0. A reset mid-operation drops all in-flight state. Responses arriving after reset with outstanding=0 follow the unexpected-response rule; the bench does not generate them.
- Issue condition: rst=1 & !redirect_valid & outstanding<MAX_OUTSTANDING & (iq_count+outstanding)<IQ_DEPTH. This reserves a queue slot per in-flight read, so a push never meets a full queue.
- On issue: imem_rmask=4'hF, imem_addr=pc, push pc into the tag FIFO, pc<=pc+4 (mod 2^32; 32'hFFFFFFFC wraps to 32'h0), outstanding++.
- Back-to-back issue: a new read may issue every cycle while the condition holds. Peak throughput is 1 instr/cycle when MAX_OUTSTANDING>=2 and memory latency is 1.
- Response (imem_resp=1, outstanding>0): pop the tag FIFO and decrement outstanding. If discard=0, push {tag_pc, imem_rdata} into the queue; otherwise drop it and decrement discard.
- Response with outstanding=0 and no same-cycle issue: ignored, fetch_err<=1 (sticky until reset).
- Issue and response in the same cycle: outstanding stays unchanged; the tag FIFO pushes and pops.
- Pop: iq_valid & iq_ready removes the head. Push and pop in the same cycle leave iq_count unchanged. Queue is circular; head/tail wrap at IQ_DEPTH.
- iq_instr/iq_pc are undefined ('x allowed) when iq_valid=0.
- Redirect (redirect_valid=1): no issue this cycle. Queue is emptied (iq_count<=0) and any same-cycle pop is ignored. pc<={redirect_pc[31:2],2'b00}. discard<=outstanding-(imem_resp?1:0); a same-cycle response is dropped. Outstanding/tag FIFO bookkeeping proceeds normally, so subsequent responses drain as discards.
- Redirect held multiple cycles: each cycle reapplies. Issue resumes in the first cycle redirect_valid=0.
- Ordering: queue output order equals PC issue order between redirects.

Test Plan:
- Reset then stream: 1-cycle-latency memory, iq_ready=1 -> first imem_addr=32'h1ECEB000 on the first cycle after reset release, then consecutive addresses +4. iq_pc sequence 1ECEB000, 1ECEB004, ... with one instr/cycle in steady state.
- Backpressure: iq_ready=0, IQ_DEPTH=8 -> exactly 8 reads issued total, iq_count reaches 8, imem_rmask stays 0. Raise iq_ready for 1 cycle -> exactly one new read issues.
- Redirect with 2 in flight: redirect_pc=32'h1ECEB103 while outstanding=2 -> both responses dropped, iq_count=0. Next issue addr=32'h1ECEB100, and the first queued iq_pc=32'h1ECEB100.
- Redirect coincident with response and pop: outstanding=2, imem_resp=1, iq_ready=1 -> discard=1, next response dropped, queue empty. The following response is pushed with the redirect target PC.
- Wrap-around: redirect_pc=32'hFFFFFFF8 -> issued addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- Errors and reset: imem_resp=1 with nothing outstanding -> fetch_err=1 and stays 1 until rst=0. Assert rst=0 mid-stream with 2 in flight -> next cycle iq_valid=0, iq_count=0, fetch_err=0, and fetch restarts at RESET_PC.
